id_hazard_scoreboard: RTL

Pipeline-interlock controller for the decode stage of the 5-stage ARM core. It keeps a per-register count of in-flight writes to the 16-entry register file, from ID issue until WB write-back. It asserts `Hazard` to the decode stage while the decoded instruction reads a register with a pending write. Hazard stall cycles are also counted for performance inspection. It replaces a purely combinational EXE/MEM destination compare, and stays correct under memory freeze and branch flush.

---
 rtl/id_hazard_scoreboard.sv | 94 +++++++++
 1 files changed

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_scoreboard
// Description : Decode-stage interlock. Tracks in-flight register writes from
//               ID issue to WB retire and stalls readers of pending registers.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_scoreboard #(
    parameter int NREG  = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  src1,
    input  logic [$clog2(NREG)-1:0]  src2,
    input  logic                     Two_src,
    input  logic [$clog2(NREG)-1:0]  Dest,
    input  logic                     id_wb_en,
    input  logic                     freeze,
    input  logic                     flush,
    input  logic                     WB_WB_en,
    input  logic [$clog2(NREG)-1:0]  WB_Dest,
    output logic                     Hazard,
    output logic [NREG-1:0]          busy_mask,
    output logic [CNT_W-1:0]         stall_count,
    output logic                     sb_overflow
);

    localparam int         c_idx_w   = $clog2(NREG);
    localparam logic [1:0] c_cnt_max = 2'd3;

    logic [1:0]       r_cnt [NREG];
    logic [CNT_W-1:0] r_stall;
    logic             r_ovf;

    logic             w_hazard;
    logic             w_issue;
    logic             w_retire;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;
    logic [NREG-1:0]  w_err;

    assign w_hazard = id_valid & ~flush &
                      ((r_cnt[src1] != 2'd0) | (Two_src & (r_cnt[src2] != 2'd0)));
    // Retire is gated by freeze so a held MEM/WB stage is counted only once.
    assign w_issue  = id_valid & id_wb_en & ~w_hazard & ~freeze & ~flush;
    assign w_retire = WB_WB_en & ~freeze;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            assign w_inc[r]     = w_issue  & (Dest    == c_idx_w'(r));
            assign w_dec[r]     = w_retire & (WB_Dest == c_idx_w'(r));
            assign w_err[r]     = (w_inc[r] & ~w_dec[r] & (r_cnt[r] == c_cnt_max)) |
                                  (w_dec[r] & ~w_inc[r] & (r_cnt[r] == 2'd0));
            assign busy_mask[r] = (r_cnt[r] != 2'd0);
        end
    endgenerate

    // Simultaneous issue and retire on one index cancel out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_inc[r] && !w_dec[r] && r_cnt[r] != c_cnt_max) begin
                    r_cnt[r] <= r_cnt[r] + 2'd1;
                end else if (w_dec[r] && !w_inc[r] && r_cnt[r] != 2'd0) begin
                    r_cnt[r] <= r_cnt[r] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_hazard && !freeze && r_stall != {CNT_W{1'b1}}) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            r_ovf <= r_ovf | (|w_err);
        end
    end

    assign Hazard      = w_hazard;
    assign stall_count = r_stall;
    assign sb_overflow = r_ovf;

endmodule
`default_nettype wire
